lfsr_decrypt_ctrl: RTL and testbench



---
 rtl/decryptor_pkg.sv | 29 ++
 rtl/lfsr6.sv | 30 +++
 rtl/lfsr_decrypt_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_lfsr_decrypt_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decryptor_pkg.sv
// decryptor_pkg: shared constants and types for the 6-bit LFSR message decryptor.
//   LFSR_PTRN  - the six maximal-length tap patterns, indexed 0..5
//   PAD_CHAR   - preamble / padding character ('_')
//   ctrl_state_t - sequencing controller states
//   lfsr_next  - one LFSR step: shift left, feed back the parity of the tapped bits
package decryptor_pkg;

    localparam int unsigned NUM_PTRN = 6;

    localparam logic [5:0] LFSR_PTRN [NUM_PTRN] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    localparam logic [7:0] PAD_CHAR = 8'h5F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_SEED,
        ST_SCAN,
        ST_SELECT,
        ST_DEC,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

    function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] taps);
        return {s[4:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr6.sv
// lfsr6: 6-bit Fibonacci-style LFSR with run-time selectable taps.
//   clk, rst - clock, asynchronous active-high reset (state clears to 0)
//   load     - load state from din (has priority over step)
//   step     - advance one LFSR step using taps
//   taps     - feedback tap mask
//   din      - load value
//   state    - current LFSR state
module lfsr6
    import decryptor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [5:0] taps,
    input  logic [5:0] din,
    output logic [5:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= din;
        end else if (step) begin
            state <= lfsr_next(state, taps);
        end
    end

endmodule

// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl: sequencing controller for the 6-bit LFSR message decryptor.
// Reads the encrypted message at MSG_BASE, recovers the seed from byte 0, finds
// which tap pattern reproduces the '_' preamble, then writes the decrypted message
// with the leading '_' run stripped to OUT_BASE.
//   clk, rst  - clock, asynchronous active-high reset
//   init      - high holds/aborts; a run starts on the first clock it is low
//   mem_raddr - registered read address (data returns one clock later on mem_rdata)
//   mem_rdata - read data
//   mem_wr_en, mem_waddr, mem_wdata - registered write port
//   done      - run finished, held until init rises
//   err       - no pattern matched (valid with done)
//   pat_idx   - selected pattern 0..5 (valid with done and !err)
//   seed      - recovered LFSR start state
module lfsr_decrypt_ctrl
    import decryptor_pkg::*;
#(
    parameter int unsigned MSG_BASE  = 64,
    parameter int unsigned OUT_BASE  = 0,
    parameter int unsigned MSG_LEN   = 64,
    parameter int unsigned CHECK_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       done,
    output logic       err,
    output logic [2:0] pat_idx,
    output logic [5:0] seed
);

    ctrl_state_t state_q, state_d;

    logic [7:0] raddr_q, raddr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] wptr_q, wptr_d;
    logic [5:0] mask_q, mask_d;
    logic [5:0] seed_q, seed_d;
    logic [2:0] pat_idx_q, pat_idx_d;
    logic       err_q, err_d;
    logic       writing_q, writing_d;

    logic       lfsr_load;
    logic       lfsr_step;
    logic [5:0] lfsr_din;
    logic [5:0] sel_taps;
    logic [5:0] inst_taps  [NUM_PTRN];
    logic [5:0] lfsr_state [NUM_PTRN];
    logic [7:0] dec_byte;

    function automatic logic [7:0] msg_addr(input logic [7:0] idx);
        return 8'(MSG_BASE) + idx;
    endfunction

    // Instance 0 doubles as the decryption LFSR once a pattern is chosen.
    always_comb begin
        sel_taps = LFSR_PTRN[0];
        for (int unsigned p = 0; p < NUM_PTRN; p++) begin
            if (pat_idx_q == 3'(p)) begin
                sel_taps = LFSR_PTRN[p];
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PTRN; p++) begin
            inst_taps[p] = LFSR_PTRN[p];
        end
        if (state_q == ST_DEC) begin
            inst_taps[0] = sel_taps;
        end
    end

    assign lfsr_din = (state_q == ST_SEED) ? 6'(mem_rdata ^ PAD_CHAR) : seed_q;

    for (genvar p = 0; p < NUM_PTRN; p++) begin : g_lfsr
        lfsr6 u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (lfsr_load),
            .step  (lfsr_step),
            .taps  (inst_taps[p]),
            .din   (lfsr_din),
            .state (lfsr_state[p])
        );
    end

    assign dec_byte = mem_rdata ^ {2'b00, lfsr_state[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        wr_en_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        mask_d    = mask_q;
        seed_d    = seed_q;
        pat_idx_d = pat_idx_q;
        err_d     = err_q;
        writing_d = writing_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!init) begin
                    state_d   = ST_RD0;
                    raddr_d   = msg_addr(8'd0);
                    seed_d    = '0;
                    pat_idx_d = '0;
                    err_d     = 1'b0;
                end
            end
            ST_RD0: begin
                state_d = ST_SEED;
                raddr_d = msg_addr(8'd1);
            end
            ST_SEED: begin
                seed_d    = 6'(mem_rdata ^ PAD_CHAR);
                lfsr_load = 1'b1;
                mask_d    = '1;
                cnt_d     = 8'd1;
                state_d   = ST_SCAN;
                raddr_d   = (CHECK_LEN > 2) ? msg_addr(8'd2) : msg_addr(8'd0);
            end
            ST_SCAN: begin
                // The LFSRs hold the state of the previous byte here, so byte cnt
                // is checked against the stepped value that the same edge commits.
                for (int unsigned p = 0; p < NUM_PTRN; p++) begin
                    if ((mem_rdata ^ {2'b00, lfsr_next(lfsr_state[p], LFSR_PTRN[p])}) != PAD_CHAR) begin
                        mask_d[p] = 1'b0;
                    end
                end
                lfsr_step = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                // Once the preamble reads are issued, byte 0 is parked on the bus
                // so that the first DEC cycle already sees it returned.
                raddr_d   = (32'(cnt_q) + 32'd2 < CHECK_LEN) ? msg_addr(cnt_q + 8'd2) : msg_addr(8'd0);
                if (cnt_q == 8'(CHECK_LEN - 1)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (mask_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    for (int unsigned p = NUM_PTRN; p > 0; p--) begin
                        if (mask_q[p-1]) begin
                            pat_idx_d = 3'(p - 1);
                        end
                    end
                    lfsr_load = 1'b1;
                    cnt_d     = 8'd0;
                    wptr_d    = 8'(OUT_BASE);
                    writing_d = 1'b0;
                    raddr_d   = msg_addr(8'd1);
                    state_d   = ST_DEC;
                end
            end
            ST_DEC: begin
                lfsr_step = 1'b1;
                if (writing_q || (dec_byte != PAD_CHAR)) begin
                    wr_en_d   = 1'b1;
                    waddr_d   = wptr_q;
                    wdata_d   = dec_byte;
                    wptr_d    = wptr_q + 8'd1;
                    writing_d = 1'b1;
                end
                cnt_d   = cnt_q + 8'd1;
                raddr_d = msg_addr(cnt_q + 8'd2);
                if (cnt_q == 8'(MSG_LEN - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (init && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q   <= '0;
            wr_en_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            mask_q    <= '0;
            seed_q    <= '0;
            pat_idx_q <= '0;
            err_q     <= 1'b0;
            writing_q <= 1'b0;
        end else begin
            raddr_q   <= raddr_d;
            wr_en_q   <= wr_en_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            mask_q    <= mask_d;
            seed_q    <= seed_d;
            pat_idx_q <= pat_idx_d;
            err_q     <= err_d;
            writing_q <= writing_d;
        end
    end

    assign mem_raddr = raddr_q;
    assign mem_wr_en = wr_en_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign pat_idx   = pat_idx_q;
    assign seed      = seed_q;

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// tb_lfsr_decrypt_ctrl: self-checking bench for lfsr_decrypt_ctrl with a
// behavioural memory and a message-level reference model.
module tb_lfsr_decrypt_ctrl;

    localparam int unsigned MSG_BASE  = 64;
    localparam int unsigned OUT_BASE  = 0;
    localparam int unsigned MSG_LEN   = 64;
    localparam int unsigned CHECK_LEN = 8;
    localparam logic [7:0]  SENTINEL  = 8'hA5;

    localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       done;
    logic       err;
    logic [2:0] pat_idx;
    logic [5:0] seed;

    logic [7:0]  mem [256];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_wr  = 0;

    logic        exp_err;
    logic [2:0]  exp_pat;
    logic [5:0]  exp_seed;
    logic [7:0]  exp_out [$];

    lfsr_decrypt_ctrl #(
        .MSG_BASE  (MSG_BASE),
        .OUT_BASE  (OUT_BASE),
        .MSG_LEN   (MSG_LEN),
        .CHECK_LEN (CHECK_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .pat_idx   (pat_idx),
        .seed      (seed)
    );

    always #5 clk = ~clk;

    // Synchronous-read, synchronous-write memory.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_waddr] = mem_wdata;
            n_wr++;
        end
        mem_rdata <= mem[mem_raddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] step6(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    // Keystream of a pattern: ks[i] is the LFSR state used for byte i.
    function automatic bit preamble_ok(input logic [7:0] m [64], input logic [5:0] sd, input int p);
        logic [5:0] ks [64];
        ks[0] = sd;
        for (int i = 1; i < 64; i++) ks[i] = step6(ks[i-1], TAPS[p]);
        for (int i = 0; i < int'(CHECK_LEN); i++) begin
            if ((m[i] ^ {2'b00, ks[i]}) != 8'h5F) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_compute();
        logic [7:0] m [64];
        logic [5:0] s;
        logic [7:0] d;
        bit         found;
        bit         skipping;
        for (int i = 0; i < 64; i++) m[i] = mem[8'(MSG_BASE + i)];
        exp_seed = 6'(m[0] ^ 8'h5F);
        found    = 1'b0;
        exp_pat  = '0;
        for (int p = 0; p < 6; p++) begin
            if (!found && preamble_ok(m, exp_seed, p)) begin
                found   = 1'b1;
                exp_pat = 3'(p);
            end
        end
        exp_err = !found;
        exp_out.delete();
        if (found) begin
            s        = exp_seed;
            skipping = 1'b1;
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                d = m[i] ^ {2'b00, s};
                s = step6(s, TAPS[exp_pat]);
                if (skipping && d == 8'h5F) continue;
                skipping = 1'b0;
                exp_out.push_back(d);
            end
        end
    endtask

    // Builds an encrypted image: pre_len '_' bytes, text, rand_len random bytes, then '_' (or random) fill.
    task automatic load_msg(input int tap_i, input logic [5:0] sd, input int pre_len,
                            input string text, input int rand_len, input bit rand_fill);
        logic [7:0] plain [64];
        logic [5:0] s;
        int         pos;
        for (int i = 0; i < 64; i++) plain[i] = rand_fill ? 8'($urandom) : 8'h5F;
        for (int i = 0; i < pre_len && i < 64; i++) plain[i] = 8'h5F;
        pos = pre_len;
        for (int j = 0; j < text.len() && pos < 64; j++) begin
            plain[pos] = text[j];
            pos++;
        end
        for (int j = 0; j < rand_len && pos < 64; j++) begin
            plain[pos] = 8'($urandom);
            pos++;
        end
        s = sd;
        for (int i = 0; i < 64; i++) begin
            mem[8'(MSG_BASE + i)] = plain[i] ^ {2'b00, s};
            s = step6(s, TAPS[tap_i]);
        end
    endtask

    task automatic clear_out();
        for (int i = 0; i < 64; i++) mem[8'(OUT_BASE + i)] = SENTINEL;
    endtask

    task automatic run_case(input string tag);
        int unsigned k;
        int unsigned wr_at_done;
        model_compute();
        clear_out();
        n_wr = 0;
        @(negedge clk);
        init = 1'b0;
        @(posedge clk);
        #1;
        k = 0;
        while (!done && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, 32'(k <= CHECK_LEN + MSG_LEN + 6), 32'd1);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!exp_err) check_eq({tag, "_pat_idx"}, 32'(pat_idx), 32'(exp_pat));
        check_eq({tag, "_seed"}, 32'(seed), 32'(exp_seed));
        check_eq({tag, "_wr_idle"}, 32'(mem_wr_en), 32'd0);
        wr_at_done = n_wr;
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_held"}, 32'(done), 32'd1);
        check_eq({tag, "_no_wr_after_done"}, n_wr, wr_at_done);
        check_eq({tag, "_n_writes"}, n_wr, 32'(exp_out.size()));
        for (int i = 0; i < 64; i++) begin
            check_eq($sformatf("%s_out[%0d]", tag, i), 32'(mem[8'(OUT_BASE + i)]),
                     32'((i < exp_out.size()) ? exp_out[i] : SENTINEL));
        end
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_done_clear"}, 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        check_eq({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_pat"}, 32'(pat_idx), 32'd0);
        check_eq({tag, "_seed"}, 32'(seed), 32'd0);
    endtask

    initial begin
        int unsigned wr_snap;
        rst  = 1'b1;
        init = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed: taps 0x21, seed 0x01, 10 underscores, "Hello"
        load_msg(0, 6'h01, 10, "Hello", 0, 1'b0);
        run_case("hello");
        check_eq("hello_pat_const", 32'(pat_idx), 32'd0);
        check_eq("hello_seed_const", 32'(seed), 32'h01);
        check_eq("hello_H", 32'(mem[0]), 32'h48);
        check_eq("hello_o", 32'(mem[4]), 32'h6F);
        check_eq("hello_pad53", 32'(mem[53]), 32'h5F);

        // Directed: taps 0x39, seed 0x3F, 8 underscores, "Zq9!"
        load_msg(5, 6'h3F, 8, "Zq9!", 0, 1'b0);
        run_case("zq9");
        check_eq("zq9_pat_const", 32'(pat_idx), 32'd5);
        check_eq("zq9_Z", 32'(mem[0]), 32'h5A);
        check_eq("zq9_bang", 32'(mem[3]), 32'h21);

        // Directed: message "__ab" after 9 underscores, taps 0x30
        load_msg(2, 6'h01, 9, "__ab", 0, 1'b0);
        run_case("ab");
        check_eq("ab_pat_const", 32'(pat_idx), 32'd2);
        check_eq("ab_a", 32'(mem[0]), 32'h61);
        check_eq("ab_b", 32'(mem[1]), 32'h62);

        // All-zero ciphertext: no pattern can match
        for (int i = 0; i < 64; i++) mem[8'(MSG_BASE + i)] = 8'h00;
        run_case("zeros");
        check_eq("zeros_err_const", 32'(err), 32'd1);
        check_eq("zeros_nwr_const", n_wr, 32'd0);

        // Abort during SCAN, then a clean rerun
        load_msg(0, 6'h01, 10, "Hello", 0, 1'b0);
        clear_out();
        n_wr = 0;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_scan_done", 32'(done), 32'd0);
        check_eq("abort_scan_wr_en", 32'(mem_wr_en), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_scan_nwr", n_wr, 32'd0);
        check_eq("abort_scan_idle_done", 32'(done), 32'd0);
        run_case("after_abort");

        // Abort during DEC while writes are streaming
        load_msg(3, 6'h15, 8, "abort-me-please", 0, 1'b0);
        clear_out();
        @(negedge clk);
        init = 1'b0;
        repeat (CHECK_LEN + 2 + 20) @(posedge clk);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_dec_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("abort_dec_done", 32'(done), 32'd0);
        wr_snap = n_wr;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_dec_no_more_wr", n_wr, wr_snap);

        // Asynchronous reset mid-DEC, then rerun of the first case
        load_msg(0, 6'h01, 10, "Hello", 0, 1'b0);
        clear_out();
        @(negedge clk);
        init = 1'b0;
        repeat (CHECK_LEN + 2 + 15) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_dec");
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_case("rerun");

        // Randomized images
        for (int r = 0; r < 10; r++) begin
            load_msg(int'($urandom_range(0, 5)), 6'($urandom), int'($urandom_range(0, 12)),
                     "", int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0));
            run_case($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
